// File: rtl/charlie_frame_scan_if.sv
// Upstream-to-scanner bundle: back-buffer row writes, commit request, and the scan/frame outputs
// consumed by the charlieplex driver.
interface charlie_frame_scan_if;
   // Handshake: wr_en and commit are single-cycle qualifiers sampled on every posedge. There is no
   // backpressure: a write is always accepted. A commit is held internally as swap_pending until
   // the copy is done. Repeated commits while pending merge into one request.
   logic        ena;
   logic        wr_en;
   logic [2:0]  wr_row;
   logic [7:0]  wr_data;
   logic        commit;
   logic [5:0]  charlie_index;
   logic [63:0] memory_frame_buffer;
   logic        frame_start;
   logic        swap_pending;
   logic        scan_active;

   modport master (
      output ena, wr_en, wr_row, wr_data, commit,
      input  charlie_index, memory_frame_buffer, frame_start, swap_pending, scan_active
   );

   modport slave (
      input  ena, wr_en, wr_row, wr_data, commit,
      output charlie_index, memory_frame_buffer, frame_start, swap_pending, scan_active
   );
endinterface

// File: rtl/charlie_frame_scan.sv
// Charlieplex scan sequencer with a double-buffered 8x8 frame store.
// The front buffer only changes at frame boundaries, or while idle, so the driver never sees a torn frame.
module charlie_frame_scan #(
   parameter int unsigned DWELL_CYCLES = 16,
   parameter bit          SKIP_DIAG    = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   charlie_frame_scan_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [5:0] FIRST      = SKIP_DIAG ? 6'd1 : 6'd0;
   localparam logic [5:0] LAST       = SKIP_DIAG ? 6'd62 : 6'd63;
   localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

   state_t      state;
   logic [7:0]  dwell;
   logic [5:0]  index_q;
   logic [63:0] front_q;
   logic [63:0] back_q;
   logic        fs_q;
   logic        pend_q;

   logic [5:0]  inc1;
   logic [5:0]  inc2;
   logic [5:0]  next_index;
   logic [63:0] back_next;
   logic        dwell_done;
   logic        boundary;
   logic        do_swap;

   // Diagonal positions have row==col, so they are not real charlieplex LEDs and are stepped over.
   always_comb begin
      inc1       = index_q + 6'd1;
      inc2       = index_q + 6'd2;
      next_index = inc1;
      if (index_q == LAST)
         next_index = FIRST;
      else if (SKIP_DIAG && (inc1[5:3] == inc1[2:0]))
         next_index = inc2;
   end

   // A same-cycle row write is folded into the copy so a swap never misses it.
   always_comb begin
      back_next = back_q;
      if (bus.wr_en)
         back_next[{bus.wr_row, 3'b000} +: 8] = bus.wr_data;
   end

   assign dwell_done = (dwell == DWELL_LAST);
   assign boundary   = ((state == IDLE) && bus.ena) ||
                       ((state == SCAN) && bus.ena && dwell_done && (index_q == LAST));
   assign do_swap    = pend_q && (boundary || (state == IDLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dwell   <= '0;
         index_q <= '0;
         front_q <= '0;
         back_q  <= '0;
         fs_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         back_q <= back_next;
         // A commit landing on the swap edge belongs to the following frame.
         if (do_swap) begin
            front_q <= back_next;
            pend_q  <= bus.commit;
         end else if (bus.commit) begin
            pend_q <= 1'b1;
         end

         case (state)
            IDLE: begin
               dwell <= '0;
               if (bus.ena) begin
                  state   <= SCAN;
                  index_q <= FIRST;
                  fs_q    <= 1'b1;
               end else begin
                  index_q <= '0;
                  fs_q    <= 1'b0;
               end
            end
            SCAN: begin
               if (!bus.ena) begin
                  state   <= IDLE;
                  index_q <= '0;
                  dwell   <= '0;
                  fs_q    <= 1'b0;
               end else if (dwell_done) begin
                  dwell   <= '0;
                  index_q <= next_index;
                  fs_q    <= (index_q == LAST);
               end else begin
                  dwell <= dwell + 8'd1;
                  fs_q  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               index_q <= '0;
               dwell   <= '0;
               fs_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.charlie_index       = index_q;
   assign bus.memory_frame_buffer = front_q;
   assign bus.frame_start         = fs_q;
   assign bus.swap_pending        = pend_q;
   assign bus.scan_active         = (state == SCAN);

endmodule

// File: tb/tb_charlie_frame_scan.sv
// Bench for charlie_frame_scan: two instances (dwell 4 with diagonal skip, dwell 1 without) share
// one stimulus stream and are checked every cycle against a frame-list model, plus literal checkpoints.
module tb_charlie_frame_scan;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic        wr_en;
   logic [2:0]  wr_row;
   logic [7:0]  wr_data;
   logic        commit;

   int n_cmp  = 0;
   int n_fail = 0;

   charlie_frame_scan_if a_if ();
   charlie_frame_scan_if b_if ();

   assign a_if.ena     = ena;
   assign a_if.wr_en   = wr_en;
   assign a_if.wr_row  = wr_row;
   assign a_if.wr_data = wr_data;
   assign a_if.commit  = commit;
   assign b_if.ena     = ena;
   assign b_if.wr_en   = wr_en;
   assign b_if.wr_row  = wr_row;
   assign b_if.wr_data = wr_data;
   assign b_if.commit  = commit;

   charlie_frame_scan #(.DWELL_CYCLES(4), .SKIP_DIAG(1'b1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   charlie_frame_scan #(.DWELL_CYCLES(1), .SKIP_DIAG(1'b0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // Each instance walks an explicit list of the LED positions in one frame.
   int          dw[2] = '{4, 1};
   bit          sk[2] = '{1'b1, 1'b0};
   logic [5:0]  seq[2][64];
   int          n_seq[2];
   bit          m_scan[2]  = '{1'b0, 1'b0};
   int          m_pos[2]   = '{0, 0};
   int          m_dwell[2] = '{0, 0};
   logic [63:0] m_front[2] = '{64'd0, 64'd0};
   logic [63:0] m_back[2]  = '{64'd0, 64'd0};
   bit          m_pend[2]  = '{1'b0, 1'b0};
   bit          m_fs[2]    = '{1'b0, 1'b0};

   task automatic build_seq();
      for (int k = 0; k < 2; k++) begin
         n_seq[k] = 0;
         for (int i = 0; i < 64; i++) begin
            if (!(sk[k] && (i / 8 == i % 8))) begin
               seq[k][n_seq[k]] = 6'(i);
               n_seq[k]++;
            end
         end
      end
   endtask

   task automatic model_reset(input int k);
      m_scan[k]  = 1'b0;
      m_pos[k]   = 0;
      m_dwell[k] = 0;
      m_front[k] = '0;
      m_back[k]  = '0;
      m_pend[k]  = 1'b0;
      m_fs[k]    = 1'b0;
   endtask

   task automatic model_step(input int k);
      logic [63:0] bn;
      bit bound;
      bit was_idle;
      bn = m_back[k];
      if (wr_en) bn[int'(wr_row) * 8 +: 8] = wr_data;
      bound    = 1'b0;
      was_idle = !m_scan[k];
      if (!m_scan[k]) begin
         m_dwell[k] = 0;
         m_pos[k]   = 0;
         if (ena) begin
            m_scan[k] = 1'b1;
            m_fs[k]   = 1'b1;
            bound     = 1'b1;
         end else begin
            m_fs[k] = 1'b0;
         end
      end else if (!ena) begin
         m_scan[k]  = 1'b0;
         m_pos[k]   = 0;
         m_dwell[k] = 0;
         m_fs[k]    = 1'b0;
      end else if (m_dwell[k] == dw[k] - 1) begin
         m_dwell[k] = 0;
         m_pos[k]   = (m_pos[k] + 1) % n_seq[k];
         m_fs[k]    = (m_pos[k] == 0);
         bound      = m_fs[k];
      end else begin
         m_dwell[k]++;
         m_fs[k] = 1'b0;
      end
      if (m_pend[k] && (bound || was_idle)) begin
         m_front[k] = bn;
         m_pend[k]  = commit;
      end else begin
         m_pend[k] = m_pend[k] | commit;
      end
      m_back[k] = bn;
   endtask

   function automatic logic [5:0] exp_index(input int k);
      return m_scan[k] ? seq[k][m_pos[k]] : 6'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s @%0t: wait budget expired", name, $time);
   endtask

   always @(negedge clk) begin
      check("a_index", 64'(a_if.charlie_index), 64'(exp_index(0)));
      check("a_front", a_if.memory_frame_buffer, m_front[0]);
      check("a_fs",    64'(a_if.frame_start), 64'(m_fs[0]));
      check("a_pend",  64'(a_if.swap_pending), 64'(m_pend[0]));
      check("b_index", 64'(b_if.charlie_index), 64'(exp_index(1)));
      check("b_front", b_if.memory_frame_buffer, m_front[1]);
      check("b_fs",    64'(b_if.frame_start), 64'(m_fs[1]));
      check("b_pend",  64'(b_if.swap_pending), 64'(m_pend[1]));
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   task automatic wait_a_index(input logic [5:0] v, input int budget, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick();
         if (a_if.charlie_index == v) hit = 1'b1;
      end
      if (!hit) timeout_fail(name);
   endtask

   task automatic wait_a_fs(input int budget, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick();
         if (a_if.frame_start) hit = 1'b1;
      end
      if (!hit) timeout_fail(name);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      build_seq();
      rst_n   = 1'b0;
      ena     = 1'b0;
      wr_en   = 1'b0;
      wr_row  = 3'd0;
      wr_data = 8'd0;
      commit  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_index", 64'(a_if.charlie_index), 64'd0);
      check("rst_a_front", a_if.memory_frame_buffer, 64'd0);
      check("rst_a_fs",    64'(a_if.frame_start), 64'd0);
      check("rst_a_pend",  64'(a_if.swap_pending), 64'd0);
      rst_n = 1'b1;
      tick();

      // Idle commit: swap one edge after swap_pending rises, index stays 0.
      wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hFF; commit = 1'b1;
      tick();
      idle_inputs();
      check("idle_pend_set",  64'(a_if.swap_pending), 64'd1);
      check("idle_front_old", a_if.memory_frame_buffer, 64'd0);
      tick();
      check("idle_front_new", a_if.memory_frame_buffer, 64'h00000000000000FF);
      check("idle_pend_clr",  64'(a_if.swap_pending), 64'd0);
      check("idle_index",     64'(a_if.charlie_index), 64'd0);

      // Frame walk: A (dwell 4, skip diag) and B (dwell 1, all 64) start together.
      ena = 1'b1;
      tick();
      check("a_first_idx", 64'(a_if.charlie_index), 64'd1);
      check("a_first_fs",  64'(a_if.frame_start), 64'd1);
      check("b_first_idx", 64'(b_if.charlie_index), 64'd0);
      check("b_first_fs",  64'(b_if.frame_start), 64'd1);
      for (int c = 1; c <= 224; c++) begin
         tick();
         if (c == 3)   check("a_hold_1",   64'(a_if.charlie_index), 64'd1);
         if (c == 4)   check("a_step_2",   64'(a_if.charlie_index), 64'd2);
         if (c == 31)  check("a_idx_8",    64'(a_if.charlie_index), 64'd8);
         if (c == 32)  check("a_skip_10",  64'(a_if.charlie_index), 64'd10);
         if (c == 62)  check("b_idx_62",   64'(b_if.charlie_index), 64'd62);
         if (c == 63)  check("b_idx_63",   64'(b_if.charlie_index), 64'd63);
         if (c == 64)  check("b_wrap_idx", 64'(b_if.charlie_index), 64'd0);
         if (c == 64)  check("b_wrap_fs",  64'(b_if.frame_start), 64'd1);
         if (c == 223) check("a_last_62",  64'(a_if.charlie_index), 64'd62);
         if (c == 224) check("a_wrap_idx", 64'(a_if.charlie_index), 64'd1);
         if (c == 224) check("a_wrap_fs",  64'(a_if.frame_start), 64'd1);
      end

      // Commit mid-frame: front held until the wrap.
      wait_a_index(6'd20, 300, "wait_idx20");
      wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5; commit = 1'b1;
      tick();
      idle_inputs();
      check("mid_pend",  64'(a_if.swap_pending), 64'd1);
      check("mid_front", a_if.memory_frame_buffer, 64'h00000000000000FF);
      wait_a_fs(300, "wait_fs_swap");
      check("wrap_front", a_if.memory_frame_buffer, 64'h00000000A50000FF);
      check("wrap_pend",  64'(a_if.swap_pending), 64'd0);

      // Write and commit on the exact boundary edge, with an earlier commit already pending.
      wait_a_index(6'd40, 300, "wait_idx40");
      commit = 1'b1;
      tick();
      idle_inputs();
      wait_a_index(6'd62, 300, "wait_idx62");
      repeat (3) tick();
      wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'h81; commit = 1'b1;
      tick();
      idle_inputs();
      check("bnd_fs",    64'(a_if.frame_start), 64'd1);
      check("bnd_front", a_if.memory_frame_buffer, 64'h81000000A50000FF);
      check("bnd_pend",  64'(a_if.swap_pending), 64'd1);
      wait_a_fs(300, "wait_fs_next");
      check("next_pend", 64'(a_if.swap_pending), 64'd0);

      // Mid-frame abort.
      wait_a_index(6'd30, 300, "wait_idx30");
      ena = 1'b0;
      tick();
      check("abort_idx", 64'(a_if.charlie_index), 64'd0);
      check("abort_fs",  64'(a_if.frame_start), 64'd0);
      repeat (5) tick();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         ena     = ($urandom_range(0, 99) < 97);
         wr_en   = ($urandom_range(0, 99) < 30);
         wr_row  = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom_range(0, 255));
         commit  = ($urandom_range(0, 99) < 4);
         tick();
      end
      ena = 1'b1;
      idle_inputs();
      repeat (7) tick();

      // Asynchronous reset mid-dwell.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_a_index", 64'(a_if.charlie_index), 64'd0);
      check("arst_a_front", a_if.memory_frame_buffer, 64'd0);
      check("arst_a_fs",    64'(a_if.frame_start), 64'd0);
      check("arst_a_pend",  64'(a_if.swap_pending), 64'd0);
      check("arst_b_front", b_if.memory_frame_buffer, 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wr_en   = ($urandom_range(0, 99) < 30);
         wr_row  = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom_range(0, 255));
         commit  = ($urandom_range(0, 99) < 5);
         tick();
      end
      idle_inputs();
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
